// File: rtl/mips_exec_units.sv
// Execution-side leaf units of the 7-stage MIPS pipeline: registered ALU, 32x32 GPR file
// with write-through, and a single-port read-first synchronous RAM. Units share only clk/rst.
module mips_exec_units #(
  parameter int MEM_WIDTH    = 32,
  parameter int MEM_WORD     = 4096,
  parameter     MEM_LOADFILE = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           alu_opcode_fwd,
  input  logic [5:0]           alu_funct_fwd,
  input  logic [5:0]           alu_opcode,
  input  logic [5:0]           alu_funct,
  input  logic [31:0]          alu_rrs,
  input  logic [31:0]          alu_rrt_in,
  input  logic [15:0]          alu_imm,
  input  logic [4:0]           alu_shamt_in,
  output logic [31:0]          alu_rslt,
  input  logic [4:0]           gpr_rs,
  input  logic [4:0]           gpr_rt,
  output logic [31:0]          gpr_rrs,
  output logic [31:0]          gpr_rrt,
  input  logic [4:0]           gpr_rd,
  input  logic [31:0]          gpr_rrd,
  input  logic                 gpr_we,
  input  logic [31:0]          mem_addr,
  input  logic [MEM_WIDTH-1:0] mem_in,
  input  logic                 mem_we,
  output logic [MEM_WIDTH-1:0] mem_out
);

  localparam int MEM_AW = $clog2(MEM_WORD);

  typedef enum logic [4:0] {
    ALU_ZERO, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV,
    ALU_ADDI, ALU_SLTI, ALU_SLTIU, ALU_ANDI, ALU_ORI, ALU_XORI, ALU_LUI
  } alu_op_e;

  alu_op_e     alu_op;
  logic [31:0] alu_next;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  // The EX-stage opcode/funct is decoded directly, so the ID-stage copies are not needed.
  logic unused_inputs;
  assign unused_inputs = ^{alu_opcode_fwd, alu_funct_fwd, mem_addr[31:MEM_AW]};

  assign imm_sext = {{16{alu_imm[15]}}, alu_imm};
  assign imm_zext = {16'h0000, alu_imm};

  always_comb begin
    alu_op = ALU_ZERO;
    case (alu_opcode)
      6'd0: begin
        case (alu_funct)
          6'd0:         alu_op = ALU_SLL;
          6'd2:         alu_op = ALU_SRL;
          6'd3:         alu_op = ALU_SRA;
          6'd4:         alu_op = ALU_SLLV;
          6'd6:         alu_op = ALU_SRLV;
          6'd7:         alu_op = ALU_SRAV;
          6'd32, 6'd33: alu_op = ALU_ADD;
          6'd34, 6'd35: alu_op = ALU_SUB;
          6'd36:        alu_op = ALU_AND;
          6'd37:        alu_op = ALU_OR;
          6'd38:        alu_op = ALU_XOR;
          6'd39:        alu_op = ALU_NOR;
          6'd42:        alu_op = ALU_SLT;
          6'd43:        alu_op = ALU_SLTU;
          default:      alu_op = ALU_ZERO;
        endcase
      end
      6'd8, 6'd9, 6'd35, 6'd43: alu_op = ALU_ADDI;
      6'd10:   alu_op = ALU_SLTI;
      6'd11:   alu_op = ALU_SLTIU;
      6'd12:   alu_op = ALU_ANDI;
      6'd13:   alu_op = ALU_ORI;
      6'd14:   alu_op = ALU_XORI;
      6'd15:   alu_op = ALU_LUI;
      default: alu_op = ALU_ZERO;
    endcase
  end

  always_comb begin
    alu_next = 32'h0;
    case (alu_op)
      ALU_ADD:   alu_next = alu_rrs + alu_rrt_in;
      ALU_SUB:   alu_next = alu_rrs - alu_rrt_in;
      ALU_AND:   alu_next = alu_rrs & alu_rrt_in;
      ALU_OR:    alu_next = alu_rrs | alu_rrt_in;
      ALU_XOR:   alu_next = alu_rrs ^ alu_rrt_in;
      ALU_NOR:   alu_next = ~(alu_rrs | alu_rrt_in);
      ALU_SLT:   alu_next = ($signed(alu_rrs) < $signed(alu_rrt_in)) ? 32'd1 : 32'd0;
      ALU_SLTU:  alu_next = (alu_rrs < alu_rrt_in) ? 32'd1 : 32'd0;
      ALU_SLL:   alu_next = alu_rrt_in << alu_shamt_in;
      ALU_SRL:   alu_next = alu_rrt_in >> alu_shamt_in;
      ALU_SRA:   alu_next = $signed(alu_rrt_in) >>> alu_shamt_in;
      ALU_SLLV:  alu_next = alu_rrt_in << alu_rrs[4:0];
      ALU_SRLV:  alu_next = alu_rrt_in >> alu_rrs[4:0];
      ALU_SRAV:  alu_next = $signed(alu_rrt_in) >>> alu_rrs[4:0];
      ALU_ADDI:  alu_next = alu_rrs + imm_sext;
      ALU_SLTI:  alu_next = ($signed(alu_rrs) < $signed(imm_sext)) ? 32'd1 : 32'd0;
      ALU_SLTIU: alu_next = (alu_rrs < imm_sext) ? 32'd1 : 32'd0;
      ALU_ANDI:  alu_next = alu_rrs & imm_zext;
      ALU_ORI:   alu_next = alu_rrs | imm_zext;
      ALU_XORI:  alu_next = alu_rrs ^ imm_zext;
      ALU_LUI:   alu_next = {alu_imm, 16'h0000};
      default:   alu_next = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) alu_rslt <= 32'h0;
    else     alu_rslt <= alu_next;
  end

  logic [31:0] gpr_regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) gpr_regs[i] <= 32'h0;
    end else if (gpr_we && gpr_rd != 5'd0) begin
      gpr_regs[gpr_rd] <= gpr_rrd;
    end
  end

  // Write-through lets ID see a value being written back in the same cycle.
  always_comb begin
    if (!rst && gpr_we && gpr_rd != 5'd0 && gpr_rd == gpr_rs) gpr_rrs = gpr_rrd;
    else if (gpr_rs == 5'd0)                                  gpr_rrs = 32'h0;
    else                                                      gpr_rrs = gpr_regs[gpr_rs];
    if (!rst && gpr_we && gpr_rd != 5'd0 && gpr_rd == gpr_rt) gpr_rrt = gpr_rrd;
    else if (gpr_rt == 5'd0)                                  gpr_rrt = 32'h0;
    else                                                      gpr_rrt = gpr_regs[gpr_rt];
  end

  logic [MEM_WIDTH-1:0] mem_array [MEM_WORD];
  logic [MEM_AW-1:0]    mem_idx;

  assign mem_idx = mem_addr[MEM_AW-1:0];

  // Read and write share one edge; the non-blocking read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (rst) mem_out <= '0;
    else     mem_out <= mem_array[mem_idx];
    if (!rst && mem_we) mem_array[mem_idx] <= mem_in;
  end

endmodule

// File: tb/tb_mips_exec_units.sv
// Scoreboard bench for mips_exec_units: a driver pushes model predictions into queues and
// two monitors pop and compare them against the registered and combinational outputs.
module tb_mips_exec_units;

  localparam int MEM_WORD = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  alu_opcode_fwd, alu_funct_fwd, alu_opcode, alu_funct;
  logic [31:0] alu_rrs, alu_rrt_in, alu_rslt;
  logic [15:0] alu_imm;
  logic [4:0]  alu_shamt_in;
  logic [4:0]  gpr_rs, gpr_rt, gpr_rd;
  logic [31:0] gpr_rrs, gpr_rrt, gpr_rrd;
  logic        gpr_we;
  logic [31:0] mem_addr, mem_in, mem_out;
  logic        mem_we;

  mips_exec_units #(.MEM_WIDTH(32), .MEM_WORD(MEM_WORD), .MEM_LOADFILE("")) dut (
    .clk(clk), .rst(rst),
    .alu_opcode_fwd(alu_opcode_fwd), .alu_funct_fwd(alu_funct_fwd),
    .alu_opcode(alu_opcode), .alu_funct(alu_funct),
    .alu_rrs(alu_rrs), .alu_rrt_in(alu_rrt_in), .alu_imm(alu_imm),
    .alu_shamt_in(alu_shamt_in), .alu_rslt(alu_rslt),
    .gpr_rs(gpr_rs), .gpr_rt(gpr_rt), .gpr_rrs(gpr_rrs), .gpr_rrt(gpr_rrt),
    .gpr_rd(gpr_rd), .gpr_rrd(gpr_rrd), .gpr_we(gpr_we),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_we(mem_we), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  op, fn;
    logic [31:0] rs, rt;
    logic [15:0] imm;
    logic [4:0]  sh;
    logic [4:0]  g_rs, g_rt, g_rd;
    logic [31:0] g_wd;
    logic        g_we;
    logic [31:0] m_addr, m_in;
    logic        m_we;
  } stim_t;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  stim_t       st;
  exp_t        alu_q[$], mem_q[$], grs_q[$], grt_q[$];
  logic [31:0] gm [32];
  logic [31:0] mm [int];
  bit          gpr_known = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] sra_ref(input logic [31:0] v, input int s);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    return (v >> s) | (v[31] ? ~(ones >> s) : 32'h0);
  endfunction

  function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [15:0] imm, input logic [4:0] sh);
    logic [31:0] sx, zx;
    sx = {{16{imm[15]}}, imm};
    zx = {16'h0, imm};
    case (op)
      0: case (fn)
        0: return b << sh;
        2: return b >> sh;
        3: return sra_ref(b, int'(sh));
        4: return b << a[4:0];
        6: return b >> a[4:0];
        7: return sra_ref(b, int'(a[4:0]));
        32, 33: return a + b;
        34, 35: return a - b;
        36: return a & b;
        37: return a | b;
        38: return a ^ b;
        39: return ~(a | b);
        42: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        43: return (a < b) ? 32'd1 : 32'd0;
        default: return 32'h0;
      endcase
      8, 9, 35, 43: return a + sx;
      10: return ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0;
      11: return (a < sx) ? 32'd1 : 32'd0;
      12: return a & zx;
      13: return a | zx;
      14: return a ^ zx;
      15: return {imm, 16'h0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, push predictions, then advance the reference model.
  task automatic applyStimulus(input string tag);
    exp_t e;
    int   a;
    @(negedge clk);
    rst = st.rst;
    alu_opcode = st.op; alu_funct = st.fn; alu_rrs = st.rs; alu_rrt_in = st.rt;
    alu_imm = st.imm; alu_shamt_in = st.sh;
    alu_opcode_fwd = $urandom_range(0, 63); alu_funct_fwd = $urandom_range(0, 63);
    gpr_rs = st.g_rs; gpr_rt = st.g_rt; gpr_rd = st.g_rd; gpr_rrd = st.g_wd; gpr_we = st.g_we;
    mem_addr = st.m_addr; mem_in = st.m_in; mem_we = st.m_we;

    e.chk = 1; e.tag = {"alu ", tag};
    e.exp = st.rst ? 32'h0 : alu_ref(st.op, st.fn, st.rs, st.rt, st.imm, st.sh);
    alu_q.push_back(e);

    a = int'(st.m_addr % MEM_WORD);
    e.tag = {"mem ", tag};
    if (st.rst)             begin e.chk = 1; e.exp = 32'h0; end
    else if (mm.exists(a))  begin e.chk = 1; e.exp = mm[a]; end
    else                    begin e.chk = 0; e.exp = 32'h0; end
    mem_q.push_back(e);
    if (!st.rst && st.m_we) mm[a] = st.m_in;

    e.chk = gpr_known;
    e.tag = {"gpr_rrs ", tag};
    e.exp = (!st.rst && st.g_we && st.g_rd != 0 && st.g_rd == st.g_rs) ? st.g_wd : gm[st.g_rs];
    grs_q.push_back(e);
    e.tag = {"gpr_rrt ", tag};
    e.exp = (!st.rst && st.g_we && st.g_rd != 0 && st.g_rd == st.g_rt) ? st.g_wd : gm[st.g_rt];
    grt_q.push_back(e);
    if (st.rst) begin
      for (int i = 0; i < 32; i++) gm[i] = 32'h0;
      gpr_known = 1;
    end else if (st.g_we && st.g_rd != 0) begin
      gm[st.g_rd] = st.g_wd;
    end
  endtask

  task automatic idleStim();
    st = '{rst: 1'b0, op: 6'd0, fn: 6'd0, rs: 32'h0, rt: 32'h0, imm: 16'h0, sh: 5'd0,
           g_rs: 5'd0, g_rt: 5'd0, g_rd: 5'd0, g_wd: 32'h0, g_we: 1'b0,
           m_addr: 32'h0, m_in: 32'h0, m_we: 1'b0};
  endtask

  task automatic setAlu(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [15:0] imm, input logic [4:0] sh);
    st.op = op; st.fn = fn; st.rs = a; st.rt = b; st.imm = imm; st.sh = sh;
  endtask

  // Registered outputs settle just after the posedge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (alu_q.size() > 0) begin
        e = alu_q.pop_front();
        if (e.chk) checkOutput(e.tag, alu_rslt, e.exp);
      end
      if (mem_q.size() > 0) begin
        e = mem_q.pop_front();
        if (e.chk) checkOutput(e.tag, mem_out, e.exp);
      end
    end
  end

  // GPR reads are combinational and sampled mid-cycle, before the writing edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (grs_q.size() > 0) begin
        e = grs_q.pop_front();
        if (e.chk) checkOutput(e.tag, gpr_rrs, e.exp);
      end
      if (grt_q.size() > 0) begin
        e = grt_q.pop_front();
        if (e.chk) checkOutput(e.tag, gpr_rrt, e.exp);
      end
    end
  end

  initial begin
    logic [5:0] op_list [18] = '{0, 0, 0, 0, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43};
    logic [5:0] fn_list [18] = '{0, 2, 3, 4, 6, 7, 8, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 1};
    logic [31:0] corner [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF};

    idleStim();
    st.rst = 1'b1;
    rst = 1'b1; alu_opcode = 0; alu_funct = 0; alu_rrs = 0; alu_rrt_in = 0; alu_imm = 0;
    alu_shamt_in = 0; alu_opcode_fwd = 0; alu_funct_fwd = 0;
    gpr_rs = 0; gpr_rt = 0; gpr_rd = 0; gpr_rrd = 0; gpr_we = 0;
    mem_addr = 0; mem_in = 0; mem_we = 0;

    applyStimulus("reset0");
    applyStimulus("reset1");

    idleStim(); setAlu(0, 33, 32'hFFFF_FFFF, 32'h1, 0, 0);
    st.m_addr = 3; st.m_in = 32'hCAFE; st.m_we = 1;
    st.g_rd = 5; st.g_wd = 32'hDEAD_BEEF; st.g_we = 1; st.g_rs = 1; st.g_rt = 2;
    applyStimulus("ADDU wrap / mem wr3 / gpr wr5");

    idleStim(); setAlu(0, 34, 32'd5, 32'd7, 0, 0);
    st.m_addr = 3; st.g_rs = 5;
    applyStimulus("SUB 5-7 / mem rd3 / gpr rd5");

    idleStim(); setAlu(0, 42, 32'hFFFF_FFFF, 32'd1, 0, 0);
    st.m_addr = 3; st.m_in = 32'hBEEF; st.m_we = 1;
    st.g_rd = 7; st.g_wd = 32'h11; st.g_we = 1; st.g_rs = 7; st.g_rt = 7;
    applyStimulus("SLT / mem read-first / gpr bypass r7");

    idleStim(); setAlu(0, 43, 32'hFFFF_FFFF, 32'd1, 0, 0);
    st.m_addr = MEM_WORD + 3;
    st.g_rd = 0; st.g_wd = 32'h55; st.g_we = 1; st.g_rs = 0; st.g_rt = 7;
    applyStimulus("SLTU / mem alias / gpr wr r0");

    idleStim(); setAlu(0, 3, 32'h0, 32'h8000_0000, 0, 5'd4);
    st.m_addr = 5; st.m_in = 32'h1111; st.m_we = 1; st.g_rs = 0; st.g_rt = 7;
    applyStimulus("SRA / mem wr5 / gpr r0 reads 0");

    idleStim(); setAlu(0, 6, 32'd36, 32'h8000_0000, 0, 0); applyStimulus("SRLV");
    idleStim(); setAlu(15, 0, 32'h0, 32'h0, 16'h1234, 0); applyStimulus("LUI");
    idleStim(); setAlu(13, 0, 32'hFFFF_0000, 32'h0, 16'h8001, 0); applyStimulus("ORI");
    idleStim(); setAlu(8, 0, 32'd10, 32'h0, 16'hFFFF, 0); applyStimulus("ADDI");
    idleStim(); setAlu(4, 0, 32'd3, 32'd3, 16'h0004, 0); applyStimulus("BEQ");

    for (int k = 0; k < 2; k++) begin
      idleStim(); setAlu(0, 33, 32'd1, 32'd1, 0, 0);
      st.rst = 1'b1;
      st.m_addr = 5; st.m_in = 32'h2222; st.m_we = 1;
      st.g_rd = 9; st.g_wd = 32'h77; st.g_we = 1; st.g_rs = 5; st.g_rt = 7;
      applyStimulus("mid reset");
    end

    idleStim(); st.m_addr = 5; st.g_rs = 9; st.g_rt = 5;
    applyStimulus("mem survives reset / gpr cleared");

    for (int n = 0; n < 400; n++) begin
      idleStim();
      st.rst = ($urandom_range(0, 63) == 0);
      st.op  = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63)) : op_list[$urandom_range(0, 17)];
      st.fn  = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63)) : fn_list[$urandom_range(0, 17)];
      st.rs  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      st.rt  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      st.imm = 16'($urandom);
      st.sh  = 5'($urandom);
      st.g_rs = 5'($urandom); st.g_rt = 5'($urandom); st.g_rd = 5'($urandom);
      if ($urandom_range(0, 3) == 0) st.g_rd = st.g_rs;
      st.g_wd = $urandom;
      st.g_we = !st.rst && ($urandom_range(0, 1) == 1);
      st.m_addr = $urandom_range(0, 2 * MEM_WORD - 1);
      st.m_in = $urandom;
      st.m_we = ($urandom_range(0, 1) == 1);
      applyStimulus("random");
    end

    repeat (3) @(negedge clk);
    checkOutput("queues drained", 32'(alu_q.size() + mem_q.size() + grs_q.size() + grt_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
